// File: rtl/reg_dump_reader.sv
// Purpose: walks a register range on the CPU readout port and streams each value out.
// Latency: first beat is valid READ_LAT cycles after the start edge; READ_LAT+1 cycles per beat with out_ready high.
// Backpressure: a beat is held stable until out_ready; the walk does not advance until the beat is taken.
//
// Ports:
//   clk        system clock, rising edge
//   startin    asynchronous reset, active-low
//   start      one-cycle dump request, only honoured when idle
//   first_reg  first register index, sampled on an accepted start
//   last_reg   last register index, sampled on an accepted start
//   regNo      register index presented to the CPU readout port
//   val        readout value from the CPU, sampled READ_LAT edges after regNo moves
//   out_valid  beat available
//   out_ready  consumer accepts beat
//   out_data   captured register value
//   out_regno  register index the beat belongs to
//   busy       dump in progress (including the done cycle)
//   done       one-cycle pulse after the final beat is accepted
//   checksum   XOR of all beats of the current dump (only with RD_CHECKSUM_EN)
//
// Optional feature macro: RD_CHECKSUM_EN adds the checksum output and its accumulator.

module reg_dump_reader #(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        startin,
  input  logic        start,
  input  logic [4:0]  first_reg,
  input  logic [4:0]  last_reg,
  output logic [4:0]  regNo,
  input  logic [31:0] val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_regno,
  output logic        busy,
  output logic        done
`ifdef RD_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Settle count reloaded each time regNo moves; 4 bits covers 1..15.
  localparam logic [3:0] LAT = 4'(READ_LAT);

  logic [1:0] state;
  logic [4:0] last_q;
  logic [3:0] cnt;

  always_ff @(posedge clk or negedge startin) begin
    if (!startin) begin
      state     <= S_IDLE;
      last_q    <= 5'd0;
      regNo     <= 5'd0;
      cnt       <= 4'd0;
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      out_regno <= 5'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            last_q <= last_reg;
            regNo  <= first_reg;
            cnt    <= LAT;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          // cnt==1 is the READ_LAT-th edge since regNo last moved.
          if (cnt == 4'd1) begin
            out_data  <= val;
            out_regno <= regNo;
            out_valid <= 1'b1;
            state     <= S_SEND;
          end
        end
        S_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (regNo == last_q) begin
              state <= S_DONE;
            end else begin
              // 5-bit add wraps 31 -> 0, which is how first>last ranges work.
              regNo <= regNo + 5'd1;
              cnt   <= LAT;
              state <= S_WAIT;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Decoded straight from the state register, so both clear immediately on reset.
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

`ifdef RD_CHECKSUM_EN
  always_ff @(posedge clk or negedge startin) begin
    if (!startin) begin
      checksum <= 32'd0;
    end else if (state == S_IDLE && start) begin
      checksum <= 32'd0;
    end else if (state == S_SEND && out_valid && out_ready) begin
      checksum <= checksum ^ out_data;
    end
  end
`endif

endmodule

// File: tb/tb_reg_dump_reader.sv
// Purpose: scoreboard bench for reg_dump_reader (READ_LAT=1 and READ_LAT=3 instances).
// Latency: expected handshake cycles are carried in the scoreboard entries.
// Backpressure: a ready driver can stall each beat for 5 cycles.

module tb_reg_dump_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        startin;

  logic        start1, out_valid1, out_ready1, busy1, done1;
  logic [4:0]  first1, last1, reg_no1, out_regno1;
  logic [31:0] val1, out_data1;

  logic        start3, out_valid3, out_ready3, busy3, done3;
  logic [4:0]  first3, last3, reg_no3, out_regno3;
  logic [31:0] val3, out_data3;

`ifdef RD_CHECKSUM_EN
  logic [31:0] checksum1, checksum3;
`endif

  logic [31:0] regs [32];
  assign val1 = regs[reg_no1];
  assign val3 = regs[reg_no3];

  reg_dump_reader #(.READ_LAT(1)) u_dut1 (
    .clk(clk), .startin(startin), .start(start1),
    .first_reg(first1), .last_reg(last1), .regNo(reg_no1), .val(val1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_regno(out_regno1), .busy(busy1), .done(done1)
`ifdef RD_CHECKSUM_EN
    , .checksum(checksum1)
`endif
  );

  reg_dump_reader #(.READ_LAT(3)) u_dut3 (
    .clk(clk), .startin(startin), .start(start3),
    .first_reg(first3), .last_reg(last3), .regNo(reg_no3), .val(val3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .out_regno(out_regno3), .busy(busy3), .done(done3)
`ifdef RD_CHECKSUM_EN
    , .checksum(checksum3)
`endif
  );

  typedef struct {
    logic [4:0]  regno;
    logic [31:0] data;
    int          hs;     // expected handshake cycle relative to start edge, -1 = any
  } beat_t;

  beat_t q1[$];
  beat_t q3[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int base1 = 0, base3 = 0;
  int n_checks = 0, n_pass = 0;
  int done_cnt1 = 0;
  bit stall_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  // Ready driver for dut1: in stall mode each new beat waits 5 cycles before ready.
  initial begin
    int stall_cnt;
    stall_cnt = 0;
    out_ready1 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!stall_mode) begin
        out_ready1 = 1'b1;
        stall_cnt  = 0;
      end else if (out_valid1 && stall_cnt < 5) begin
        out_ready1 = 1'b0;
        stall_cnt++;
      end else if (out_valid1) begin
        out_ready1 = 1'b1;
      end else begin
        out_ready1 = 1'b0;
        stall_cnt  = 0;
      end
    end
  end

  // Monitor for dut1: compares beats at handshake, checks hold while stalled, counts done pulses.
  initial begin
    bit          stalled;
    logic [31:0] hd;
    logic [4:0]  hr;
    beat_t       e;
    stalled = 1'b0;
    hd = 32'd0;
    hr = 5'd0;
    forever begin
      @(negedge clk);
      if (!startin) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("hold_valid", 32'(out_valid1), 32'd1);
          check("hold_regno", 32'(out_regno1), 32'(hr));
          check("hold_data", out_data1, hd);
        end
        if (out_valid1 && out_ready1) begin
          check("beat_expected1", 32'(q1.size() != 0), 32'd1);
          if (q1.size() != 0) begin
            e = q1.pop_front();
            check("beat_regno1", 32'(out_regno1), 32'(e.regno));
            check("beat_data1", out_data1, e.data);
            if (e.hs >= 0) check("hs_cycle1", 32'(cyc - base1), 32'(e.hs));
          end
        end
        stalled = out_valid1 && !out_ready1;
        hr = out_regno1;
        hd = out_data1;
        if (done1) done_cnt1++;
      end
    end
  end

  // Monitor for dut3 (always ready).
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (startin && out_valid3 && out_ready3) begin
        check("beat_expected3", 32'(q3.size() != 0), 32'd1);
        if (q3.size() != 0) begin
          e = q3.pop_front();
          check("beat_regno3", 32'(out_regno3), 32'(e.regno));
          check("beat_data3", out_data3, e.data);
          if (e.hs >= 0) check("hs_cycle3", 32'(cyc - base3), 32'(e.hs));
        end
      end
    end
  end

  task automatic push1(input logic [4:0] f, input logic [4:0] l, input bit timed);
    beat_t e;
    int n;
    n = int'(5'(l - f)) + 1;
    for (int k = 0; k < n; k++) begin
      e.regno = f + 5'(k);
      e.data  = regs[e.regno];
      e.hs    = timed ? (2 * k + 1) : -1;
      q1.push_back(e);
    end
  endtask

  task automatic push3(input logic [4:0] f, input logic [4:0] l);
    beat_t e;
    int n;
    n = int'(5'(l - f)) + 1;
    for (int k = 0; k < n; k++) begin
      e.regno = f + 5'(k);
      e.data  = regs[e.regno];
      e.hs    = 4 * k + 3;
      q3.push_back(e);
    end
  endtask

  task automatic do_start1(input logic [4:0] f, input logic [4:0] l);
    @(posedge clk);
    #1 first1 = f; last1 = l; start1 = 1'b1;
    @(posedge clk);
    #1 base1 = cyc; start1 = 1'b0;
  endtask

  task automatic do_start3(input logic [4:0] f, input logic [4:0] l);
    @(posedge clk);
    #1 first3 = f; last3 = l; start3 = 1'b1;
    @(posedge clk);
    #1 base3 = cyc; start3 = 1'b0;
  endtask

  task automatic wait_done1(input int budget, output int rel);
    rel = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done1) begin
        rel = cyc - base1;
        break;
      end
    end
    check("done1_seen", 32'(done1), 32'd1);
  endtask

  initial begin
    int  rel;
    int  dc;
    bit  found;
    startin = 1'b0;
    start1 = 1'b0; first1 = 5'd0; last1 = 5'd0;
    start3 = 1'b0; first3 = 5'd0; last3 = 5'd0;
    out_ready3 = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h1111_1111;

    // Reset state
    #12;
    check("rst_regno", 32'(reg_no1), 32'd0);
    check("rst_valid", 32'(out_valid1), 32'd0);
    check("rst_data", out_data1, 32'd0);
    check("rst_oregno", 32'(out_regno1), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_valid3", 32'(out_valid3), 32'd0);
`ifdef RD_CHECKSUM_EN
    check("rst_checksum", checksum1, 32'd0);
`endif
    @(negedge clk);
    startin = 1'b1;
    repeat (2) @(posedge clk);

    // Full dump 0..31, READ_LAT=1, ready high
    push1(5'd0, 5'd31, 1'b1);
    do_start1(5'd0, 5'd31);
    wait_done1(200, rel);
    check("t1_done_cycle", 32'(rel), 32'd64);
    check("t1_busy_in_done", 32'(busy1), 32'd1);
    check("t1_all_beats", 32'(q1.size()), 32'd0);
    @(negedge clk);
    check("t1_busy_low", 32'(busy1), 32'd0);

    // Backpressure 4..6
    stall_mode = 1'b1;
    push1(5'd4, 5'd6, 1'b0);
    do_start1(5'd4, 5'd6);
    wait_done1(200, rel);
    check("t2_all_beats", 32'(q1.size()), 32'd0);
    stall_mode = 1'b0;

    // Wrap 30..1 on READ_LAT=3
    push3(5'd30, 5'd1);
    do_start3(5'd30, 5'd1);
    rel = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done3) begin
        rel = cyc - base3;
        break;
      end
    end
    check("t3_done_cycle", 32'(rel), 32'd16);
    check("t3_all_beats", 32'(q3.size()), 32'd0);

    // Single register, start held through WAIT, SEND and DONE
    dc = done_cnt1;
    push1(5'd7, 5'd7, 1'b1);
    do_start1(5'd7, 5'd7);
    first1 = 5'd0; last1 = 5'd31; start1 = 1'b1;
    repeat (3) @(posedge clk);
    #1 start1 = 1'b0;
    repeat (5) @(negedge clk);
    check("t4_one_done", 32'(done_cnt1), 32'(dc + 1));
    check("t4_idle", 32'(busy1), 32'd0);
    check("t4_all_beats", 32'(q1.size()), 32'd0);

    // Reset while the second beat is stalled
    stall_mode = 1'b1;
    push1(5'd10, 5'd12, 1'b0);
    do_start1(5'd10, 5'd12);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid1 && out_regno1 == 5'd11) begin
        found = 1'b1;
        break;
      end
    end
    check("t5_second_beat_seen", 32'(found), 32'd1);
    #2 startin = 1'b0;
    #1;
    check("t5_rst_valid", 32'(out_valid1), 32'd0);
    check("t5_rst_busy", 32'(busy1), 32'd0);
    check("t5_rst_done", 32'(done1), 32'd0);
    check("t5_rst_regno", 32'(reg_no1), 32'd0);
    check("t5_rst_data", out_data1, 32'd0);
    dc = done_cnt1;
    q1.delete();
    stall_mode = 1'b0;
    repeat (3) @(negedge clk);
    startin = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_no_done_pulse", 32'(done_cnt1), 32'(dc));
    push1(5'd10, 5'd12, 1'b1);
    do_start1(5'd10, 5'd12);
    wait_done1(100, rel);
    check("t5_done_cycle", 32'(rel), 32'd6);
    check("t5_all_beats", 32'(q1.size()), 32'd0);

`ifdef RD_CHECKSUM_EN
    // Checksum over r1..r3
    regs[1] = 32'hA5A5_A5A5;
    regs[2] = 32'h0F0F_0F0F;
    regs[3] = 32'hFFFF_FFFF;
    push1(5'd1, 5'd3, 1'b1);
    do_start1(5'd1, 5'd3);
    wait_done1(100, rel);
    check("t6_checksum", checksum1, 32'h5555_5555);
    push1(5'd1, 5'd3, 1'b1);
    do_start1(5'd1, 5'd3);
    @(negedge clk);
    check("t6_checksum_cleared", checksum1, 32'd0);
    wait_done1(100, rel);
    check("t6_checksum_again", checksum1, 32'h5555_5555);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks %0d passed %0d", n_checks, n_pass);
    $fatal(1);
  end

endmodule
